// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// State encoding, status bit positions and common keyboard commands.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_BITS,
    ST_LINEACK,
    ST_RELEASE
  } tx_state_e;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;
  localparam int STAT_DROP = 3;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_sync.sv
// Two-flop synchroniser for the PS/2 clock and data pins with a
// registered falling-edge pulse aligned to the synchronised clock.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_i,
  input  logic data_i,
  output logic clk_s,
  output logic data_s,
  output logic fall
);

  logic [1:0] clk_ff_q, clk_ff_d;
  logic [1:0] dat_ff_q, dat_ff_d;
  logic       fall_q, fall_d;

  always_comb begin
    clk_ff_d = {clk_ff_q[0], clk_i};
    dat_ff_d = {dat_ff_q[0], data_i};
    // high in the same cycle clk_s first reads 0
    fall_d   = clk_ff_q[1] & ~clk_ff_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_ff_q <= 2'b11;
      dat_ff_q <= 2'b11;
      fall_q   <= 1'b0;
    end else begin
      clk_ff_q <= clk_ff_d;
      dat_ff_q <= dat_ff_d;
      fall_q   <= fall_d;
    end
  end

  assign clk_s  = clk_ff_q[1];
  assign data_s = dat_ff_q[1];
  assign fall   = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Wishbone slave sending one host-to-device PS/2 command byte
// over open-drain clock/data drives, with status readback.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned RTS_CYCLES     = 50,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        STB,
  input  logic        WE,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK,
  input  logic        kbd_clk_i,
  input  logic        kbd_data_i,
  output logic        kbd_clk_drive_low,
  output logic        kbd_data_drive_low,
  output logic        tx_active
);

  localparam int unsigned PH_MAX =
    (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int CW = $clog2(PH_MAX) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          par_q, par_d;
  logic          clk_drv_q, clk_drv_d;
  logic          dat_drv_q, dat_drv_d;
  logic          ack_q, ack_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          drop_q, drop_d;

  logic       line_clk, line_dat, line_fall;
  logic       wr;
  logic [9:0] frame;
  logic       unused_dat_hi;

  ps2_line_sync u_sync (
    .clk    (clk),
    .rst_n  (reset),
    .clk_i  (kbd_clk_i),
    .data_i (kbd_data_i),
    .clk_s  (line_clk),
    .data_s (line_dat),
    .fall   (line_fall)
  );

  assign wr            = STB & WE & ~ack_q;
  assign frame         = {1'b1, par_q, byte_q};
  assign unused_dat_hi = ^DAT_I[31:8];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    par_d     = par_q;
    clk_drv_d = clk_drv_q;
    dat_drv_d = dat_drv_q;
    done_d    = done_q;
    err_d     = err_q;
    drop_d    = drop_q;
    ack_d     = STB & ~ack_q;

    unique case (state_q)
      ST_IDLE: begin
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
        if (wr) begin
          byte_d    = DAT_I[7:0];
          par_d     = odd_parity(DAT_I[7:0]);
          done_d    = 1'b0;
          err_d     = 1'b0;
          drop_d    = 1'b0;
          cnt_d     = '0;
          clk_drv_d = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          dat_drv_d = 1'b1;
          state_d   = ST_RTS;
        end
      end
      ST_RTS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RTS_LAST) begin
          clk_drv_d = 1'b0;
          tmo_d     = '0;
          idx_d     = '0;
          state_d   = ST_BITS;
        end
      end
      ST_BITS: begin
        if (line_fall) begin
          dat_drv_d = ~frame[idx_q];
          idx_d     = idx_q + 1'b1;
          if (idx_q == 4'd9) state_d = ST_LINEACK;
        end
      end
      ST_LINEACK: begin
        if (line_fall) begin
          done_d  = ~line_dat;
          err_d   = line_dat;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (line_clk && line_dat) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // the device gets a bounded window from clock release to line ACK
    if (state_q == ST_BITS || state_q == ST_LINEACK ||
        state_q == ST_RELEASE) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_q == TMO_LAST) begin
        err_d     = 1'b1;
        done_d    = 1'b0;
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
        state_d   = ST_IDLE;
      end
    end

    if (wr && state_q != ST_IDLE) drop_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      idx_q     <= '0;
      byte_q    <= '0;
      par_q     <= 1'b0;
      clk_drv_q <= 1'b0;
      dat_drv_q <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      idx_q     <= idx_d;
      byte_q    <= byte_d;
      par_q     <= par_d;
      clk_drv_q <= clk_drv_d;
      dat_drv_q <= dat_drv_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
    end
  end

  assign tx_active          = (state_q != ST_IDLE);
  assign ACK                = ack_q;
  assign kbd_clk_drive_low  = clk_drv_q;
  assign kbd_data_drive_low = dat_drv_q;

  always_comb begin
    DAT_O            = '0;
    DAT_O[STAT_BUSY] = tx_active;
    DAT_O[STAT_DONE] = done_q;
    DAT_O[STAT_ERR]  = err_q;
    DAT_O[STAT_DROP] = drop_q;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, a clocking keyboard
// model, a per-cycle bus/drive-schedule checker and directed cases.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int RTS = 5;
  localparam int TMO = 1000;
  // device half-period, scaled down from 12.5 kHz to keep runs short
  localparam int H   = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        STB = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] DAT_I = '0;
  logic [31:0] DAT_O;
  logic        ACK;
  logic        kbd_clk_i, kbd_data_i;
  logic        kbd_clk_drive_low, kbd_data_drive_low;
  logic        tx_active;

  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  int   dev_falls = 0;

  int n_checks = 0;
  int n_pass = 0;
  bit arm = 1'b0;

  assign kbd_clk_i  = dev_clk & ~kbd_clk_drive_low;
  assign kbd_data_i = dev_data & ~kbd_data_drive_low;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .RTS_CYCLES     (RTS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                (clk),
    .reset              (rst_n),
    .STB                (STB),
    .WE                 (WE),
    .DAT_I              (DAT_I),
    .DAT_O              (DAT_O),
    .ACK                (ACK),
    .kbd_clk_i          (kbd_clk_i),
    .kbd_data_i         (kbd_data_i),
    .kbd_clk_drive_low  (kbd_clk_drive_low),
    .kbd_data_drive_low (kbd_data_drive_low),
    .tx_active          (tx_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic bound_fail(input string nm);
    n_checks++;
    $display("FAIL %s: wait bound expired got timeout expected event", nm);
  endtask

  // frame as the device sees it: data LSB-first, odd parity, stop=1
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    int ones;
    logic p;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    p = (ones % 2 == 0);
    return {1'b1, p, b};
  endfunction

  // per-cycle checks: registered ACK rule and inhibit/RTS schedule
  int ph = 0;
  bit exp_ack = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ph = 0;
      exp_ack = 1'b0;
    end else begin
      chk("ack_rule", ACK, exp_ack);
      chk("dat_o_hi", DAT_O[31:4], 0);
      if (ph > 0) begin
        if (ph <= INH) begin
          chk("inh_clk", kbd_clk_drive_low, 1);
          chk("inh_dat", kbd_data_drive_low, 0);
        end else if (ph <= INH + RTS) begin
          chk("rts_clk", kbd_clk_drive_low, 1);
          chk("rts_dat", kbd_data_drive_low, 1);
        end else begin
          chk("rel_clk", kbd_clk_drive_low, 0);
          chk("rel_start", kbd_data_drive_low, 1);
        end
        ph = (ph > INH + RTS) ? 0 : ph + 1;
      end
      if (STB && WE && !exp_ack && arm) begin
        ph = 1;
        arm = 1'b0;
      end
      exp_ack = STB && !exp_ack;
    end
  end

  task automatic device(input bit do_ack, output logic [9:0] cap);
    int n;
    cap = '0;
    n = 0;
    while (kbd_clk_drive_low !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      bound_fail("dev_inhibit");
      return;
    end
    n = 0;
    while (kbd_clk_drive_low !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      bound_fail("dev_rts");
      return;
    end
    chk("start_bit", kbd_data_i, 0);
    repeat (H) @(negedge clk);
    for (int f = 1; f <= 11; f++) begin
      dev_clk = 1'b0;
      dev_falls++;
      repeat (H) @(negedge clk);
      if (f <= 10) cap[f-1] = kbd_data_i;
      dev_clk = 1'b1;
      if (f == 10 && do_ack) dev_data = 1'b0;
      repeat (H) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic bus_write(input logic [7:0] d, output logic ack_seen);
    @(posedge clk);
    #1;
    STB = 1'b1;
    WE = 1'b1;
    DAT_I = {24'hA5A5A5, d};
    @(posedge clk);
    #1;
    ack_seen = ACK;
    STB = 1'b0;
    WE = 1'b0;
  endtask

  task automatic bus_read(output logic [31:0] st);
    @(posedge clk);
    #1;
    STB = 1'b1;
    WE = 1'b0;
    @(posedge clk);
    #1;
    st = DAT_O;
    STB = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (tx_active && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) bound_fail(nm);
  endtask

  task automatic run_frame(input logic [7:0] b, input bit do_ack,
                           output logic [9:0] cap);
    logic a;
    arm = 1'b1;
    fork
      device(do_ack, cap);
      begin
        bus_write(b, a);
        chk("wr_ack", a, 1);
      end
    join
    wait_idle("idle_wait");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0]  cap;
    logic [31:0] st;
    logic        a;
    int          n;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_dat_o", DAT_O, 0);
    chk("rst_ack", ACK, 0);
    chk("rst_clk_drv", kbd_clk_drive_low, 0);
    chk("rst_dat_drv", kbd_data_drive_low, 0);
    chk("rst_active", tx_active, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 0xED with device ACK
    run_frame(8'hED, 1'b1, cap);
    chk("ed_frame_lit", cap, 10'h3ED);
    chk("ed_frame_model", cap, frame_of(8'hED));
    bus_read(st);
    chk("ed_status", st, 32'h2);
    chk("ed_active", tx_active, 0);
    chk("ed_clk_drv", kbd_clk_drive_low, 0);
    chk("ed_dat_drv", kbd_data_drive_low, 0);

    // parity boundaries
    run_frame(8'h00, 1'b1, cap);
    chk("p00_parity", cap[8], 1);
    chk("p00_frame", cap, 10'h300);
    run_frame(8'h01, 1'b1, cap);
    chk("p01_parity", cap[8], 0);
    chk("p01_frame", cap, 10'h201);

    // no line ACK from device
    run_frame(8'hFF, 1'b0, cap);
    chk("noack_frame", cap, frame_of(8'hFF));
    bus_read(st);
    chk("noack_status", st, 32'h4);
    chk("noack_clk_drv", kbd_clk_drive_low, 0);
    chk("noack_dat_drv", kbd_data_drive_low, 0);

    // device never clocks: timeout from clock release
    arm = 1'b1;
    bus_write(8'h42, a);
    chk("tmo_wr_ack", a, 1);
    n = 0;
    while (kbd_clk_drive_low !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) bound_fail("tmo_release");
    n = 0;
    while (DAT_O[2] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_clk_drv", kbd_clk_drive_low, 0);
    chk("tmo_dat_drv", kbd_data_drive_low, 0);
    bus_read(st);
    chk("tmo_status", st, 32'h4);

    // write while busy is dropped
    arm = 1'b1;
    fork
      device(1'b1, cap);
      begin
        bus_write(8'hF4, a);
        chk("drop_ack1", a, 1);
        @(posedge clk);
        #1;
        chk("drop_ack1_low", ACK, 0);
        bus_write(8'h55, a);
        chk("drop_ack2", a, 1);
        bus_read(st);
        chk("drop_busy_status", st, 32'h9);
      end
    join
    wait_idle("drop_idle");
    chk("drop_frame", cap, frame_of(8'hF4));
    bus_read(st);
    chk("drop_final_status", st, 32'hA);

    // reset mid-BITS
    arm = 1'b1;
    n = dev_falls;
    fork
      device(1'b1, cap);
      begin
        bus_write(8'hFF, a);
        while (dev_falls < n + 4) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_clk_drv", kbd_clk_drive_low, 0);
        chk("mid_rst_dat_drv", kbd_data_drive_low, 0);
        chk("mid_rst_ack", ACK, 0);
        chk("mid_rst_active", tx_active, 0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    bus_read(st);
    chk("post_rst_status", st, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Wishbone slave that sends one command byte from the host to the PS/2 keyboard, for example 0xED (set LEDs) or 0xFF (reset).
- It drives the PS/2 clock and data lines through open-drain enables.
- It runs the host-to-device frame: inhibit, request-to-send, 8 data bits LSB-first, odd parity, stop bit, then samples the device's line ACK.
- It sits beside the keyboard receiver on the same kbd_clk/kbd_data pins and the same intercon slave bus.
- While a frame is in flight, `tx_active` tells the receiver to ignore line activity.

Parameters:
- INHIBIT_CYCLES, 5000: clocks the host holds kbd_clk low before requesting to send (100 us at 50 MHz).
- RTS_CYCLES, 50: clocks data is held low together with clock low before clock is released.
- TIMEOUT_CYCLES, 1000000: maximum clocks from clock release to device ACK (20 ms at 50 MHz).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- STB, input, 1: Wishbone strobe (slave select from intercon).
- WE, input, 1: write enable.
- DAT_I, input, 32: write data; bits [7:0] are the command byte.
- DAT_O, output, 32: status word.
- ACK, output, 1: Wishbone acknowledge.
- kbd_clk_i, input, 1: raw PS/2 clock pin level.
- kbd_data_i, input, 1: raw PS/2 data pin level.
- kbd_clk_drive_low, output, 1: 1 = pull PS/2 clock low; 0 = release it.
- kbd_data_drive_low, output, 1: 1 = pull PS/2 data low; 0 = release it.
- tx_active, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- **Reset** (reset=0, async):
  - FSM goes to IDLE; all counters clear.
  - ACK=0, DAT_O=0, kbd_clk_drive_low=0, kbd_data_drive_low=0, tx_active=0.
  - Status bits clear.
- **Synchronisation:** kbd_clk_i and kbd_data_i each pass through a 2-FF synchroniser. fall = synchronised clock was 1 in the previous cycle and is 0 now.
- **Bus handshake:**
  - ACK is registered.
  - ACK=1 for exactly one cycle, in the cycle after STB=1 is sampled while ACK=0.
  - Every access is acknowledged; there are no wait states.
- **Status word** (DAT_O[31:4]=0):
  - bit0 busy (= tx_active).
  - bit1 done: device ACK received.
  - bit2 err: timeout, or no device ACK.
  - bit3 drop: a write arrived while busy.
  - DAT_O updates every cycle.
- **Writes:**
  - Write (STB & WE, first cycle) in IDLE: latch DAT_I[7:0]; compute parity = ~^byte (odd); clear done/err/drop; enter INHIBIT.
  - Write while busy: byte discarded, drop=1, frame unaffected.
  - Reads have no side effects.
- **FSM:**
  - IDLE: both drive signals 0.
  - INHIBIT: clk_drive=1 for INHIBIT_CYCLES, then go to RTS.
  - RTS: clk_drive=1, data_drive=1 (start bit 0) for RTS_CYCLES. Then clk_drive=0, clear the timeout counter, go to BITS.
  - BITS (index 0..9; 0-7 data, 8 parity, 9 stop):
    - On each fall: data_drive = ~bit[index], index+1.
    - The stop bit drives data_drive=0 (line released = 1).
    - After the fall that launches the stop bit, go to LINEACK.
  - LINEACK: on the next fall, sample synchronised data.
    - 0: done=1, go to RELEASE.
    - 1: err=1, go to RELEASE.
  - RELEASE: wait until synchronised clock=1 and synchronised data=1, then go to IDLE.
- **Timeout:**
  - The counter runs in BITS, LINEACK and RELEASE.
  - On reaching TIMEOUT_CYCLES: err=1, both drive signals 0, go to IDLE.
  - done is never set by a timed-out frame.
- **Edge cases:**
  - Device holds the clock low at clock release: no fall occurs, so the timeout path is taken.
  - A write in the same cycle as the return to IDLE is treated as busy (drop=1).
  - Reset mid-frame releases both lines immediately.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, INHIBIT, RTS, BITS, LINEACK, RELEASE).
  - Status bit positions (BUSY=0, DONE=1, ERR=2, DROP=3).
  - PS/2 command constants (0xED, 0xF4, 0xFF).
- One sub-module: ps2_line_sync, the 2-FF synchroniser plus registered falling-edge pulse. The keyboard receiver can reuse it.

Test Plan:
- Write 0xED with a device model clocking at 12.5 kHz and ACKing → bits driven 1,0,1,1,0,1,1,1 (LSB-first), then parity 1, stop released. Status reads 0x2; tx_active=0 afterwards.
- Write 0x00 → parity bit 1; write 0x01 → parity bit 0. Checked at the 9th fall.
- Device model omits the line ACK (data stays 1) → status 0x4; both lines released.
- Device never clocks after RTS (TIMEOUT_CYCLES=1000 in bench) → err=1 exactly 1000 cycles after clock release; status 0x4.
- Second write during a frame → ACK pulses one cycle, drop=1 (status 0x9 while busy). First byte completes unchanged; final status 0xA.
- Assert reset=0 mid-BITS → within the same cycle both drive signals=0 and ACK=0. After release, status reads 0x0.
